gray_paddle_tracker: RTL
========================

Name: gray_paddle_tracker

Overview:
- Sits directly downstream of the camera RAW-to-RGB stage.
- Consumes its 8-bit grayscale pixel stream, qualified by the same read-request and vertical-sync signals, and thresholds each pixel inside a programmable column window.
- Accumulates count and row-sum of bright pixels per frame, then runs a sequential divider at frame end to produce the bright-object centroid row.
- The pong game logic uses that row as the player paddle position.

Parameters:
- H_ACTIVE, 640, valid pixels per line (X counter saturates at H_ACTIVE-1).
- V_ACTIVE, 480, valid lines per frame (lines at or beyond this are ignored).
- X_MIN, 0, first column of tracking window (inclusive).
- X_MAX, 159, last column of tracking window (inclusive).
- THRESH, 200, pixel counts as bright when iGRAY >= THRESH.
- MIN_COUNT, 64, minimum bright pixels per frame for a valid detection.

Ports:
- VGA_CLK  input  1  pixel clock; sole clock.
- RST  input  1  asynchronous, active-high reset.
- iGRAY  input  8  grayscale pixel, valid when iREAD_Request=1.
- iREAD_Request  input  1  pixel valid; high for one contiguous run per line.
- iVGA_VS  input  1  vertical sync, active low; falling edge marks frame end.
- oPADDLE_Y  output  10  centroid row of last valid detection.
- oFOUND  output  1  1 if last completed frame met MIN_COUNT.
- oUPDATE  output  1  one-cycle pulse when oPADDLE_Y/oFOUND are refreshed.
- oBUSY  output  1  high while divider is running.
- oDROP  output  1  one-cycle pulse when a frame snapshot is discarded.

Behaviour:
Reset:
- On RST high, asynchronously: oPADDLE_Y=240, oFOUND=0, oUPDATE=0, oBUSY=0, oDROP=0.
- All counters, accumulators and edge-detect registers clear; state=IDLE.

Input edge detection:
- iREAD_Request and iVGA_VS are registered once to detect edges.

Pixel and line counters:
- x_cnt increments on every cycle with iREAD_Request=1, saturating at H_ACTIVE-1.
- On the falling edge of iREAD_Request: x_cnt<=0, and y_cnt increments, saturating at V_ACTIVE.
- A pixel is in-window when X_MIN<=x_cnt<=X_MAX and y_cnt<V_ACTIVE.
- An in-window pixel with iGRAY>=THRESH adds 1 to cnt_acc (19 bit) and y_cnt to sum_acc (28 bit). Both saturate at all-ones; they never wrap.

Frame end (falling edge of iVGA_VS, detected one cycle after the input edge):
- Snapshot cnt_acc and sum_acc.
- Clear cnt_acc, sum_acc, x_cnt and y_cnt in the same cycle.
- A bright pixel arriving in that same cycle is counted into the new frame.

State machine: IDLE -> DIVIDE -> DONE -> IDLE.
- IDLE, snapshot with cnt >= MIN_COUNT: load divider, go to DIVIDE, oBUSY=1.
- IDLE, snapshot with cnt < MIN_COUNT: next cycle oFOUND<=0, oUPDATE=1; oPADDLE_Y holds its previous value; stay in IDLE.
- DIVIDE: unsigned restoring division sum/cnt, one quotient bit per cycle, 28 iterations, then go to DONE.
- DONE: oPADDLE_Y <= quotient[9:0], clamped to V_ACTIVE-1; oFOUND<=1; oUPDATE=1 for one cycle; oBUSY<=0; go to IDLE.
- Latency: frame-end edge detected at cycle T gives oUPDATE at T+30.

Boundary conditions:
- A frame-end edge arriving while in DIVIDE or DONE: the new snapshot is discarded, oDROP pulses 1 cycle, and the divide in progress completes unaffected.
- A frame with zero valid lines is handled as cnt=0: not found.
- RST asserted mid-DIVIDE aborts the divide and returns all outputs to reset values; no oUPDATE is produced.

Test Plan:
- Reset check: RST high mid-frame -> oPADDLE_Y=240, oFOUND=0, oBUSY=0, no oUPDATE until after the next frame end.
- Solid bright box: rows 100..139, columns 10..49 at gray 255, rest 0 -> at VS fall, oUPDATE exactly 30 cycles later, oPADDLE_Y=119, oFOUND=1.
- Out-of-window rejection: same box placed at columns 300..339 -> oFOUND=0, oUPDATE 1 cycle after edge, oPADDLE_Y unchanged at 119.
- Threshold and MIN_COUNT boundaries:
  - 63 pixels at gray 200 in window -> oFOUND=0.
  - 64 pixels at gray 200 in row 50 -> oPADDLE_Y=50, oFOUND=1.
  - 64 pixels at gray 199 -> oFOUND=0.
- Drop path: force a second VS falling edge 10 cycles after the first -> oDROP one-cycle pulse; the first result still delivered at T+30 and is correct.
- Reset during DIVIDE: assert RST 15 cycles after frame end -> no oUPDATE; outputs at reset values; next full frame yields the correct centroid.

Source files
------------

// File: rtl/gray_paddle_tracker.sv
// gray_paddle_tracker: thresholds the grayscale pixel stream inside a column
// window, accumulates count and row-sum of bright pixels per frame, and at
// frame end divides them sequentially to get the bright-object centroid row.
//
// Ports:
//   VGA_CLK        pixel clock (sole clock)
//   RST            asynchronous active-high reset
//   iGRAY          8-bit grayscale pixel, valid while iREAD_Request=1
//   iREAD_Request  pixel valid, one contiguous run per line
//   iVGA_VS        vertical sync, active low; falling edge ends the frame
//   oPADDLE_Y      centroid row of the last valid detection
//   oFOUND         last completed frame had enough bright pixels
//   oUPDATE        one-cycle pulse when oPADDLE_Y/oFOUND are refreshed
//   oBUSY          divider running
//   oDROP          one-cycle pulse when a frame snapshot is discarded
module gray_paddle_tracker #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 159,
  parameter int unsigned THRESH    = 200,
  parameter int unsigned MIN_COUNT = 64
) (
  input  logic       VGA_CLK,
  input  logic       RST,
  input  logic [7:0] iGRAY,
  input  logic       iREAD_Request,
  input  logic       iVGA_VS,
  output logic [9:0] oPADDLE_Y,
  output logic       oFOUND,
  output logic       oUPDATE,
  output logic       oBUSY,
  output logic       oDROP
);

  localparam int unsigned XW        = 10;
  localparam int unsigned YW        = 10;
  localparam int unsigned CW        = 19;
  localparam int unsigned SW        = 28;
  localparam int unsigned IW        = 5;
  localparam int unsigned DIV_ITERS = 28;
  localparam logic [YW-1:0] PADDLE_RESET = YW'(240);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  logic          req_q, vs_q;
  logic          req_fall, vs_fall;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          x_lo_ok, in_win, bright;
  logic [CW-1:0] cnt_acc;
  logic [SW-1:0] sum_acc;
  logic [SW:0]   sum_inc;
  logic          snap_valid;
  logic [CW-1:0] snap_cnt;
  logic [SW-1:0] snap_sum;

  state_t        state, state_d;
  logic [CW-1:0] rem, rem_d;
  logic [SW-1:0] quo, quo_d;
  logic [CW-1:0] dvsr, dvsr_d;
  logic [IW-1:0] iter, iter_d;
  logic [CW:0]   trial;
  logic [YW-1:0] paddle_d;
  logic          found_d, update_d, busy_d, drop_d;

  // Edge detection on the stream qualifiers
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      req_q <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      req_q <= iREAD_Request;
      vs_q  <= iVGA_VS;
    end
  end

  assign req_fall = req_q & ~iREAD_Request;
  assign vs_fall  = vs_q & ~iVGA_VS;

  // Lower window bound is a no-op when the window starts at column 0
  generate
    if (X_MIN == 0) begin : g_xmin_zero
      assign x_lo_ok = 1'b1;
    end else begin : g_xmin
      assign x_lo_ok = (x_cnt >= XW'(X_MIN));
    end
  endgenerate

  assign in_win  = x_lo_ok && (x_cnt <= XW'(X_MAX)) && (y_cnt < YW'(V_ACTIVE));
  assign bright  = iREAD_Request && in_win && (iGRAY >= 8'(THRESH));
  assign sum_inc = {1'b0, sum_acc} + (SW+1)'(y_cnt);

  // Column/row position counters
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (vs_fall) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (req_fall) begin
      x_cnt <= '0;
      if (y_cnt != YW'(V_ACTIVE)) y_cnt <= y_cnt + YW'(1);
    end else if (iREAD_Request && (x_cnt != XW'(H_ACTIVE - 1))) begin
      x_cnt <= x_cnt + XW'(1);
    end
  end

  // Saturating bright-pixel accumulators
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      cnt_acc <= '0;
      sum_acc <= '0;
    end else if (vs_fall) begin
      // A bright pixel on the frame-end cycle opens the new frame at row 0
      cnt_acc <= bright ? CW'(1) : '0;
      sum_acc <= '0;
    end else if (bright) begin
      if (cnt_acc != '1) cnt_acc <= cnt_acc + CW'(1);
      sum_acc <= sum_inc[SW] ? '1 : sum_inc[SW-1:0];
    end
  end

  // Frame-end snapshot, only accepted while the divider is idle
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      snap_valid <= 1'b0;
      snap_cnt   <= '0;
      snap_sum   <= '0;
    end else begin
      snap_valid <= vs_fall && (state == IDLE);
      if (vs_fall && (state == IDLE)) begin
        snap_cnt <= cnt_acc;
        snap_sum <= sum_acc;
      end
    end
  end

  // FSM and divider state register
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      iter      <= '0;
      oPADDLE_Y <= PADDLE_RESET;
      oFOUND    <= 1'b0;
      oUPDATE   <= 1'b0;
      oBUSY     <= 1'b0;
      oDROP     <= 1'b0;
    end else begin
      state     <= state_d;
      rem       <= rem_d;
      quo       <= quo_d;
      dvsr      <= dvsr_d;
      iter      <= iter_d;
      oPADDLE_Y <= paddle_d;
      oFOUND    <= found_d;
      oUPDATE   <= update_d;
      oBUSY     <= busy_d;
      oDROP     <= drop_d;
    end
  end

  // Next-state: restoring divide, quotient shifts in where the dividend shifts out
  always_comb begin
    state_d  = state;
    rem_d    = rem;
    quo_d    = quo;
    dvsr_d   = dvsr;
    iter_d   = iter;
    paddle_d = oPADDLE_Y;
    found_d  = oFOUND;
    busy_d   = oBUSY;
    update_d = 1'b0;
    drop_d   = vs_fall && (state != IDLE);
    trial    = {rem, quo[SW-1]};

    case (state)
      IDLE: begin
        if (snap_valid) begin
          if (snap_cnt >= CW'(MIN_COUNT)) begin
            quo_d   = snap_sum;
            rem_d   = '0;
            dvsr_d  = snap_cnt;
            iter_d  = IW'(DIV_ITERS - 1);
            busy_d  = 1'b1;
            state_d = DIVIDE;
          end else begin
            found_d  = 1'b0;
            update_d = 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (trial >= {1'b0, dvsr}) begin
          rem_d = CW'(trial - {1'b0, dvsr});
          quo_d = {quo[SW-2:0], 1'b1};
        end else begin
          rem_d = trial[CW-1:0];
          quo_d = {quo[SW-2:0], 1'b0};
        end
        iter_d = iter - IW'(1);
        if (iter == '0) state_d = DONE;
      end
      DONE: begin
        paddle_d = (quo > SW'(V_ACTIVE - 1)) ? YW'(V_ACTIVE - 1) : quo[YW-1:0];
        found_d  = 1'b1;
        update_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
